// File: rtl/branch_update_queue.sv
// In-order queue of predicted branches that drives the local predictor's update port on resolve.
// Optional saturating statistics counters are built when BRANCH_UPDATE_STATS_EN is defined.
module branch_update_queue #(
    parameter int DEPTH   = 4,
    parameter int PC_BITS = 7
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [PC_BITS-1:0]         push_pc,
    input  logic                       push_pred,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    input  logic                       resolve_valid,
    input  logic                       resolve_taken,
    output logic                       upd_write_enabled,
    output logic                       upd_outcome,
    output logic [PC_BITS-1:0]         upd_pc_bits_write,
    output logic                       mispredict,
    output logic                       overflow_err,
    output logic                       underflow_err,
    output logic [15:0]                stat_resolved,
    output logic [15:0]                stat_mispredicts
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Handshake: push and resolve_valid are single-cycle strobes with no ready.
    // A push is accepted when not full or when a correct resolve pops in the
    // same cycle; the producer must watch full. A resolve is accepted when not
    // empty. Rejected strobes raise the sticky overflow/underflow flags.
    logic [PC_BITS-1:0] pc_mem_q   [DEPTH];
    logic               pred_mem_q [DEPTH];
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               do_pop, do_push, mis;
    logic               upd_we_q, upd_outcome_q, mispredict_q;
    logic [PC_BITS-1:0] upd_pc_q;
    logic               overflow_q, underflow_q;

    assign do_pop  = resolve_valid && (count_q != '0);
    assign mis     = do_pop && (pred_mem_q[rd_ptr_q] != resolve_taken);
    // A push alongside a mispredict is wrong-path: dropped silently.
    assign do_push = push && !mis && ((count_q != FULL_CNT) || do_pop);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (mis) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            upd_we_q      <= 1'b0;
            upd_outcome_q <= 1'b0;
            upd_pc_q      <= '0;
            mispredict_q  <= 1'b0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                pred_mem_q[i] <= 1'b0;
            end
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            upd_we_q     <= do_pop;
            mispredict_q <= mis;
            if (do_pop) begin
                upd_outcome_q <= resolve_taken;
                upd_pc_q      <= pc_mem_q[rd_ptr_q];
            end
            if (do_push) begin
                pc_mem_q[wr_ptr_q]   <= push_pc;
                pred_mem_q[wr_ptr_q] <= push_pred;
            end
            if (push && (count_q == FULL_CNT) && !do_pop) overflow_q <= 1'b1;
            if (resolve_valid && (count_q == '0))         underflow_q <= 1'b1;
        end
    end

`ifdef BRANCH_UPDATE_STATS_EN
    logic [15:0] stat_res_q, stat_mis_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_res_q <= '0;
            stat_mis_q <= '0;
        end else begin
            if (do_pop && (stat_res_q != 16'hFFFF)) stat_res_q <= stat_res_q + 16'd1;
            if (mis && (stat_mis_q != 16'hFFFF))    stat_mis_q <= stat_mis_q + 16'd1;
        end
    end

    assign stat_resolved    = stat_res_q;
    assign stat_mispredicts = stat_mis_q;
`else
    assign stat_resolved    = 16'h0000;
    assign stat_mispredicts = 16'h0000;
`endif

    assign count             = count_q;
    assign full              = (count_q == FULL_CNT);
    assign empty             = (count_q == '0);
    assign upd_write_enabled = upd_we_q;
    assign upd_outcome       = upd_outcome_q;
    assign upd_pc_bits_write = upd_pc_q;
    assign mispredict        = mispredict_q;
    assign overflow_err      = overflow_q;
    assign underflow_err     = underflow_q;

endmodule

// File: tb/tb_branch_update_queue.sv
// Directed bench for branch_update_queue; expected predictor updates go through a scoreboard queue.
module tb_branch_update_queue;

    localparam int DEPTH   = 4;
    localparam int PC_BITS = 7;
    localparam int UW      = PC_BITS + 2;

    logic               clk;
    logic               reset;
    logic               push;
    logic [PC_BITS-1:0] push_pc;
    logic               push_pred;
    logic               full;
    logic               empty;
    logic [2:0]         count;
    logic               resolve_valid;
    logic               resolve_taken;
    logic               upd_write_enabled;
    logic               upd_outcome;
    logic [PC_BITS-1:0] upd_pc_bits_write;
    logic               mispredict;
    logic               overflow_err;
    logic               underflow_err;
    logic [15:0]        stat_resolved;
    logic [15:0]        stat_mispredicts;

    // {outcome, pc, mispredict}
    logic [UW-1:0] exp_q[$];
    int            total_checks = 0;
    int            fail_checks  = 0;

    branch_update_queue #(.DEPTH(DEPTH), .PC_BITS(PC_BITS)) dut (
        .clk               (clk),
        .reset             (reset),
        .push              (push),
        .push_pc           (push_pc),
        .push_pred         (push_pred),
        .full              (full),
        .empty             (empty),
        .count             (count),
        .resolve_valid     (resolve_valid),
        .resolve_taken     (resolve_taken),
        .upd_write_enabled (upd_write_enabled),
        .upd_outcome       (upd_outcome),
        .upd_pc_bits_write (upd_pc_bits_write),
        .mispredict        (mispredict),
        .overflow_err      (overflow_err),
        .underflow_err     (underflow_err),
        .stat_resolved     (stat_resolved),
        .stat_mispredicts  (stat_mispredicts)
    );

    // clock / watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act !== exp) begin
            fail_checks++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic cycle(input logic p, input logic [PC_BITS-1:0] pc, input logic pr,
                         input logic rv, input logic rt);
        push          = p;
        push_pc       = pc;
        push_pred     = pr;
        resolve_valid = rv;
        resolve_taken = rt;
        @(posedge clk);
        #1;
        push          = 1'b0;
        resolve_valid = 1'b0;
    endtask

    task automatic do_push(input logic [PC_BITS-1:0] pc, input logic pr);
        cycle(1'b1, pc, pr, 1'b0, 1'b0);
    endtask

    task automatic expect_upd(input logic outcome, input logic [PC_BITS-1:0] pc, input logic mis);
        exp_q.push_back({outcome, pc, mis});
    endtask

    // monitor: every update strobe must match the oldest expected update
    initial begin
        logic [UW-1:0] exp;
        forever begin
            @(negedge clk);
            if (upd_write_enabled === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("upd_unexpected", {upd_outcome, upd_pc_bits_write, mispredict}, '0);
                    if ({upd_outcome, upd_pc_bits_write, mispredict} == '0) begin
                        total_checks++;
                        fail_checks++;
                        $display("FAIL upd_unexpected: got strobe required none");
                    end
                end else begin
                    exp = exp_q.pop_front();
                    check("upd", {upd_outcome, upd_pc_bits_write, mispredict}, exp);
                end
            end else if (mispredict !== 1'b0) begin
                total_checks++;
                fail_checks++;
                $display("FAIL mispredict_no_strobe: got %b required 0", mispredict);
            end
        end
    end

    initial begin
        push = 0; push_pc = '0; push_pred = 0; resolve_valid = 0; resolve_taken = 0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_upd", {upd_write_enabled, upd_outcome, upd_pc_bits_write, mispredict}, 0);
        check("rst_errs", {overflow_err, underflow_err}, 0);
        check("rst_stats", {stat_resolved, stat_mispredicts}, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // basic in-order update
        do_push(7'h12, 1'b1);
        do_push(7'h34, 1'b0);
        check("t1_count2", count, 2);
        expect_upd(1'b1, 7'h12, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
        check("t1_count1", count, 1);
        expect_upd(1'b0, 7'h34, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("t1_empty", empty, 1);

        // mispredict flushes younger entries and drops the same-cycle push
        do_push(7'h05, 1'b0);
        do_push(7'h06, 1'b1);
        do_push(7'h07, 1'b1);
        check("t2_count3", count, 3);
        expect_upd(1'b1, 7'h05, 1'b1);
        cycle(1'b1, 7'h08, 1'b0, 1'b1, 1'b1);
        check("t2_count0", count, 0);
        check("t2_empty", empty, 1);
        check("t2_no_ovf", overflow_err, 0);

        // full: drop, then push with pop while full
        do_push(7'h01, 1'b1);
        do_push(7'h02, 1'b1);
        do_push(7'h03, 1'b1);
        do_push(7'h04, 1'b1);
        check("t3_full", full, 1);
        do_push(7'h09, 1'b1);
        check("t3_ovf", overflow_err, 1);
        check("t3_count_drop", count, 4);
        expect_upd(1'b1, 7'h01, 1'b0);
        cycle(1'b1, 7'h0A, 1'b1, 1'b1, 1'b1);
        check("t3_count_swap", count, 4);
        expect_upd(1'b1, 7'h02, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
        expect_upd(1'b1, 7'h03, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
        expect_upd(1'b1, 7'h04, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
        expect_upd(1'b0, 7'h0A, 1'b1);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("t3_drained", empty, 1);

        // resolve on empty, with a simultaneous push that is still accepted
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
        check("t4_unf", underflow_err, 1);
        check("t4_no_strobe", upd_write_enabled, 0);
        cycle(1'b1, 7'h11, 1'b0, 1'b1, 1'b0);
        check("t4_push_kept", count, 1);
        expect_upd(1'b0, 7'h11, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

        // pointer wrap: entry 0x20+k carries pred k[0]
        do_push(7'h20, 1'b0);
        for (int i = 0; i < 10; i++) begin
            logic [PC_BITS-1:0] npc;
            logic [PC_BITS-1:0] hpc;
            npc = 7'h21 + PC_BITS'(i);
            hpc = 7'h20 + PC_BITS'(i);
            expect_upd(i[0], hpc, 1'b0);
            cycle(1'b1, npc, ~i[0], 1'b1, i[0]);
        end
        check("t5_count1", count, 1);
        expect_upd(1'b0, 7'h2A, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
        check("t5_empty", empty, 1);

        @(negedge clk);
`ifdef BRANCH_UPDATE_STATS_EN
        check("stat_resolved", stat_resolved, 20);
        check("stat_mispredicts", stat_mispredicts, 2);
`else
        check("stat_resolved", stat_resolved, 0);
        check("stat_mispredicts", stat_mispredicts, 0);
`endif

        // asynchronous reset mid-cycle
        @(posedge clk);
        #1;
        do_push(7'h40, 1'b1);
        do_push(7'h41, 1'b1);
        do_push(7'h42, 1'b1);
        check("t6_count3", count, 3);
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check("t6_async_count", count, 0);
        check("t6_async_empty", empty, 1);
        check("t6_async_outs", {upd_write_enabled, upd_outcome, upd_pc_bits_write, mispredict,
                                overflow_err, underflow_err}, 0);
        check("t6_async_stats", {stat_resolved, stat_mispredicts}, 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        do_push(7'h50, 1'b1);
        expect_upd(1'b1, 7'h50, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", total_checks - fail_checks, total_checks);
        $finish;
    end

endmodule
